// File: rtl/game_pkg.sv
// Shared definitions for the raccoon/road game: externally visible game states,
// default game limits and the level-to-car-speed mapping.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_RUN  = 2'b01,
    GS_WIN  = 2'b10,
    GS_OVER = 2'b11
  } game_state_e;

  localparam int C_LIVES_DEFAULT     = 3;
  localparam int C_MAX_LEVEL_DEFAULT = 9;
  localparam int C_SPEED_MAX         = 15;

  // Level 0 (idle) shows the base speed; otherwise base + level - 1, clamped to 0..15.
  function automatic logic [3:0] speed_for_level(input int base, input logic [3:0] level);
    int sum;
    if (level == 4'd0) sum = base;
    else               sum = base + int'(level) - 1;
    if (sum > C_SPEED_MAX) sum = C_SPEED_MAX;
    if (sum < 0)           sum = 0;
    return 4'(sum);
  endfunction

endpackage

// File: rtl/flow_timer.sv
// Loadable down-counter used for the post-hit freeze and the between-level pause.
// o_Done is high whenever the count has reached zero.
module flow_timer #(
  parameter int C_WIDTH = 4
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Load,
  input  logic [C_WIDTH-1:0] i_Load_Val,
  input  logic               i_Dec,
  output logic               o_Done
);

  localparam logic [C_WIDTH-1:0] C_ONE = C_WIDTH'(1);

  logic [C_WIDTH-1:0] r_count;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_count <= '0;
    end else if (i_Load) begin
      r_count <= i_Load_Val;
    end else if (i_Dec && (r_count != '0)) begin
      r_count <= r_count - C_ONE;
    end
  end

  assign o_Done = (r_count == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Central sequencer for the raccoon/road game: owns lives, level and phase, turns
// level-sensitive collision/goal inputs into one-shot events and drives car/raccoon control.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int C_LIVES      = C_LIVES_DEFAULT,
  parameter int C_MAX_LEVEL  = C_MAX_LEVEL_DEFAULT,
  parameter int C_HIT_CYCLES = 12_500_000,
  parameter int C_LVL_CYCLES = 12_500_000,
  parameter int C_BASE_SPEED = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic [1:0] o_Game_State,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Respawn,
  output logic       o_Cars_En,
  output logic [3:0] o_Car_Speed
);

  localparam int C_TMR_MAX = (C_HIT_CYCLES > C_LVL_CYCLES) ? C_HIT_CYCLES : C_LVL_CYCLES;
  localparam int C_TMR_W   = (C_TMR_MAX > 0) ? $clog2(C_TMR_MAX + 1) : 1;

  localparam logic [C_TMR_W-1:0] C_HIT_LOAD   = C_TMR_W'(C_HIT_CYCLES);
  localparam logic [C_TMR_W-1:0] C_LVL_LOAD   = C_TMR_W'(C_LVL_CYCLES);
  localparam logic [1:0]         C_LIVES_INIT = 2'(C_LIVES);
  localparam logic [3:0]         C_LEVEL_MAX  = 4'(C_MAX_LEVEL);
  localparam logic [3:0]         C_SPEED_INIT = speed_for_level(C_BASE_SPEED, 4'd0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HIT,
    ST_LVL,
    ST_WIN,
    ST_OVER
  } flow_state_e;

  // Asynchronous assertion, release aligned to the clock two edges later.
  logic [1:0] r_rst_pipe;
  logic       w_rst;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_rst_pipe <= 2'b11;
    else         r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end

  assign w_rst = r_rst_pipe[1];

  // Edge history resets high so a button still held at power-up never starts a game.
  logic r_start_meta;
  logic r_start_sync;
  logic r_start_prev;
  logic w_start_edge;

  always_ff @(posedge i_Clk or posedge w_rst) begin
    if (w_rst) begin
      r_start_meta <= 1'b1;
      r_start_sync <= 1'b1;
      r_start_prev <= 1'b1;
    end else begin
      r_start_meta <= i_Start;
      r_start_sync <= r_start_meta;
      r_start_prev <= r_start_sync;
    end
  end

  assign w_start_edge = r_start_sync & ~r_start_prev;

  flow_state_e       r_state;
  flow_state_e       w_state_next;
  logic [1:0]        r_lives;
  logic [1:0]        w_lives_next;
  logic [3:0]        r_level;
  logic [3:0]        w_level_next;
  logic              r_respawn;
  logic              w_respawn_next;
  logic              r_cars_en;
  logic              w_cars_en_next;
  logic [1:0]        r_game_state;
  logic [1:0]        w_game_state_next;
  logic [3:0]        r_car_speed;
  logic [3:0]        w_car_speed_next;
  logic              w_tmr_load;
  logic [C_TMR_W-1:0] w_tmr_load_val;
  logic              w_tmr_dec;
  logic              w_tmr_done;

  flow_timer #(
    .C_WIDTH (C_TMR_W)
  ) u_flow_timer (
    .i_Clk      (i_Clk),
    .i_Reset    (w_rst),
    .i_Load     (w_tmr_load),
    .i_Load_Val (w_tmr_load_val),
    .i_Dec      (w_tmr_dec),
    .o_Done     (w_tmr_done)
  );

  always_ff @(posedge i_Clk or posedge w_rst) begin
    if (w_rst) begin
      r_state      <= ST_IDLE;
      r_lives      <= C_LIVES_INIT;
      r_level      <= 4'd0;
      r_respawn    <= 1'b0;
      r_cars_en    <= 1'b0;
      r_game_state <= GS_IDLE;
      r_car_speed  <= C_SPEED_INIT;
    end else begin
      r_state      <= w_state_next;
      r_lives      <= w_lives_next;
      r_level      <= w_level_next;
      r_respawn    <= w_respawn_next;
      r_cars_en    <= w_cars_en_next;
      r_game_state <= w_game_state_next;
      r_car_speed  <= w_car_speed_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_lives_next   = r_lives;
    w_level_next   = r_level;
    w_respawn_next = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = C_HIT_LOAD;
    w_tmr_dec      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_next   = ST_RUN;
          w_lives_next   = C_LIVES_INIT;
          w_level_next   = 4'd1;
          w_respawn_next = 1'b1;
        end
      end
      ST_RUN: begin
        // Collision has priority; a simultaneous goal is dropped.
        if (i_Collision) begin
          if (r_lives != 2'd0) w_lives_next = r_lives - 2'd1;
          w_respawn_next = 1'b1;
          if (w_lives_next == 2'd0) begin
            w_state_next = ST_OVER;
          end else begin
            w_state_next   = ST_HIT;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = C_HIT_LOAD;
          end
        end else if (i_Goal) begin
          if (r_level >= C_LEVEL_MAX) begin
            w_state_next = ST_WIN;
          end else begin
            w_level_next   = r_level + 4'd1;
            w_respawn_next = 1'b1;
            w_state_next   = ST_LVL;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = C_LVL_LOAD;
          end
        end
      end
      ST_HIT, ST_LVL: begin
        if (w_tmr_done) w_state_next = ST_RUN;
        else            w_tmr_dec    = 1'b1;
      end
      ST_WIN, ST_OVER: begin
        if (w_start_edge) begin
          w_state_next = ST_IDLE;
          w_lives_next = C_LIVES_INIT;
          w_level_next = 4'd0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (r_respawn) w_respawn_next = 1'b0;
  end

  always_comb begin
    w_game_state_next = GS_IDLE;
    case (w_state_next)
      ST_RUN, ST_HIT, ST_LVL: w_game_state_next = GS_RUN;
      ST_WIN:                 w_game_state_next = GS_WIN;
      ST_OVER:                w_game_state_next = GS_OVER;
      default:                w_game_state_next = GS_IDLE;
    endcase
    w_cars_en_next   = (w_state_next == ST_RUN);
    w_car_speed_next = speed_for_level(C_BASE_SPEED, w_level_next);
  end

  assign o_Game_State = r_game_state;
  assign o_Lives      = r_lives;
  assign o_Level      = r_level;
  assign o_Respawn    = r_respawn;
  assign o_Cars_En    = r_cars_en;
  assign o_Car_Speed  = r_car_speed;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a cycle model pushes expected outputs as
// stimulus is driven; they are popped and compared one clock later.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int P_LIVES = 3;
  localparam int P_MAX   = 3;
  localparam int P_HIT   = 4;
  localparam int P_LVL   = 2;
  localparam int P_BASE  = 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;
  localparam int M_LVL  = 3;
  localparam int M_WIN  = 4;
  localparam int M_OVER = 5;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       coll  = 1'b0;
  logic       goal  = 1'b0;
  logic [1:0] gs;
  logic [1:0] lives;
  logic [3:0] level;
  logic       resp;
  logic       cars;
  logic [3:0] speed;

  game_flow_ctrl #(
    .C_LIVES      (P_LIVES),
    .C_MAX_LEVEL  (P_MAX),
    .C_HIT_CYCLES (P_HIT),
    .C_LVL_CYCLES (P_LVL),
    .C_BASE_SPEED (P_BASE)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Start      (start),
    .i_Collision  (coll),
    .i_Goal       (goal),
    .o_Game_State (gs),
    .o_Lives      (lives),
    .o_Level      (level),
    .o_Respawn    (resp),
    .o_Cars_En    (cars),
    .o_Car_Speed  (speed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gs;
    int lives;
    int level;
    int resp;
    int cars;
    int speed;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  int m_ph, m_lives, m_level, m_wait, m_resp, m_s1, m_s2, m_prev, m_hold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph    = M_IDLE;
    m_lives = P_LIVES;
    m_level = 0;
    m_wait  = 0;
    m_resp  = 0;
    m_s1    = 1;
    m_s2    = 1;
    m_prev  = 1;
    m_hold  = 2;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input int s, input int c, input int g);
    int edge_seen;
    int pulse;
    if (m_hold > 0) begin
      m_hold--;
      return;
    end
    edge_seen = (m_s2 == 1 && m_prev == 0) ? 1 : 0;
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = s;
    pulse  = 0;
    case (m_ph)
      M_IDLE: if (edge_seen == 1) begin
        m_ph = M_RUN; m_lives = P_LIVES; m_level = 1; pulse = 1;
      end
      M_RUN: begin
        if (c == 1) begin
          m_lives = m_lives - 1;
          pulse = 1;
          if (m_lives == 0) m_ph = M_OVER;
          else begin m_ph = M_HIT; m_wait = P_HIT; end
        end else if (g == 1) begin
          if (m_level == P_MAX) m_ph = M_WIN;
          else begin m_level++; pulse = 1; m_ph = M_LVL; m_wait = P_LVL; end
        end
      end
      M_HIT, M_LVL: begin
        if (m_wait == 0) m_ph = M_RUN;
        else m_wait--;
      end
      default: if (edge_seen == 1) begin
        m_ph = M_IDLE; m_lives = P_LIVES; m_level = 0;
      end
    endcase
    if (m_resp == 1) pulse = 0;
    m_resp = pulse;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    case (m_ph)
      M_IDLE:  e.gs = 0;
      M_WIN:   e.gs = 2;
      M_OVER:  e.gs = 3;
      default: e.gs = 1;
    endcase
    e.lives = m_lives;
    e.level = m_level;
    e.resp  = m_resp;
    e.cars  = (m_ph == M_RUN) ? 1 : 0;
    if (m_level == 0) e.speed = P_BASE;
    else e.speed = (P_BASE + m_level - 1 > 15) ? 15 : P_BASE + m_level - 1;
    return e;
  endfunction

  task automatic cycle(input logic s, input logic c, input logic g);
    exp_t e;
    start = s;
    coll  = c;
    goal  = g;
    model_step(int'(s), int'(c), int'(g));
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    n_cyc++;
    $display("[TB] cyc %0d st=%0b col=%0b gl=%0b -> gs=%0d lives=%0d level=%0d resp=%0d cars=%0d speed=%0d",
             n_cyc, s, c, g, gs, lives, level, resp, cars, speed);
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val($sformatf("c%0d_state", n_cyc), 32'(gs), e.gs);
      check_val($sformatf("c%0d_lives", n_cyc), 32'(lives), e.lives);
      check_val($sformatf("c%0d_level", n_cyc), 32'(level), e.level);
      check_val($sformatf("c%0d_respawn", n_cyc), 32'(resp), e.resp);
      check_val($sformatf("c%0d_cars_en", n_cyc), 32'(cars), e.cars);
      check_val($sformatf("c%0d_speed", n_cyc), 32'(speed), e.speed);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"},   32'(gs),    32'd0);
    check_val({tag, "_lives"},   32'(lives), 32'(P_LIVES));
    check_val({tag, "_level"},   32'(level), 32'd0);
    check_val({tag, "_respawn"}, 32'(resp),  32'd0);
    check_val({tag, "_cars_en"}, 32'(cars),  32'd0);
    check_val({tag, "_speed"},   32'(speed), 32'(P_BASE));
  endtask

  task automatic apply_reset(input logic s);
    start = s;
    coll  = 1'b0;
    goal  = 1'b0;
    rst   = 1'b1;
    model_reset();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    #2;
    apply_reset(1'b0);

    // Start from idle, then a quiet stretch in RUN.
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Collision held: one life per entry into RUN, ending in game over.
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Over -> idle -> run.
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Goals at levels 1, 2 and finally the last level.
    for (int lv = 1; lv <= P_MAX; lv++) begin
      cycle(1'b0, 1'b0, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 1'b0);
    end

    // Win -> idle -> run, then collision and goal together.
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Reset asserted between clock edges while in HIT, start held through release.
    start = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    apply_reset(1'b1);
    repeat (8) cycle(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
